// File: rtl/fifo_pkg.sv
// Shared sizing constants for the synchronous FIFO and its storage.
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned PTR_W_DEF = ptr_w(FIFO_DEPTH_DEF);

endpackage

// File: rtl/sdpram.sv
// Simple dual-port RAM: synchronous write, asynchronous read, no reset on contents.
module sdpram_core
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_wr_en,
  input  logic [ptr_w(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic [ptr_w(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]        o_rd_data
);

  logic [WIDTH-1:0] mem_array [0:DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_array[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_array[i_rd_addr];

endmodule

module sdpram
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_wr_en,
  input  logic [ptr_w(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic [ptr_w(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]        o_rd_data
);

  sdpram_core #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) sdpram_i1 (
    .i_clk     (i_clk),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered active-low flags and a sticky error bit.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  ReadClk,
  input  logic                  WriteClk,
  input  logic                  Reset_,
  input  logic                  WriteEn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  ReadEn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  Empty_,
  output logic                  HalfFull_,
  output logic                  Full_,
  output logic                  Error
);

  localparam int unsigned PTR_W = ptr_w(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_empty_n;
  logic                  r_half_n;
  logic                  r_full_n;
  logic                  r_error;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_mem_we;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  w_err_nxt;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused_writeclk;

  assign w_unused_writeclk = WriteClk;

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  always_comb begin
    w_rd_acc    = ReadEn && (r_count != CNT_W'(0));
    w_wr_acc    = WriteEn && ((r_count != CNT_W'(FIFO_DEPTH)) || w_rd_acc);
    w_mem_we    = w_wr_acc && !Reset_;
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
    w_err_nxt = r_error || (WriteEn && !w_wr_acc) || (ReadEn && !w_rd_acc);
  end

  always_ff @(posedge ReadClk) begin
    if (Reset_) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_empty_n  <= 1'b0;
      r_half_n   <= 1'b1;
      r_full_n   <= 1'b1;
      r_error    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_data_out <= w_rd_data;
      end
      r_count   <= w_count_nxt;
      r_empty_n <= (w_count_nxt != CNT_W'(0));
      r_half_n  <= (w_count_nxt < CNT_W'(FIFO_DEPTH / 2));
      r_full_n  <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
      r_error   <= w_err_nxt;
    end
  end

  sdpram #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) sdpram_i1 (
    .i_clk     (ReadClk),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (DataIn),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign DataOut   = r_data_out;
  assign Empty_    = r_empty_n;
  assign HalfFull_ = r_half_n;
  assign Full_     = r_full_n;
  assign Error     = r_error;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_sync_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned W     = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         we;
  logic         re;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         empty_n;
  logic         half_n;
  logic         full_n;
  logic         err;

  always #5 clk = ~clk;

  sync_fifo #(
    .FIFO_DEPTH (DEPTH),
    .DATA_WIDTH (W)
  ) dut (
    .ReadClk   (clk),
    .WriteClk  (clk),
    .Reset_    (rst),
    .WriteEn   (we),
    .DataIn    (din),
    .ReadEn    (re),
    .DataOut   (dout),
    .Empty_    (empty_n),
    .HalfFull_ (half_n),
    .Full_     (full_n),
    .Error     (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout = '0;
  bit           m_err  = 1'b0;
  bit           m_rd_ok;
  bit           m_wr_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is simply the queue length.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_dout = '0;
      m_err  = 1'b0;
    end else begin
      m_rd_ok = re && (mq.size() > 0);
      m_wr_ok = we && ((mq.size() < DEPTH) || m_rd_ok);
      if (m_rd_ok) m_dout = mq.pop_front();
      if (m_wr_ok) mq.push_back(din);
      if ((we && !m_wr_ok) || (re && !m_rd_ok)) m_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dataout", 32'(dout), 32'(m_dout));
      check("model_empty_n", 32'(empty_n), 32'(mq.size() != 0));
      check("model_half_n", 32'(half_n), 32'(mq.size() < DEPTH / 2));
      check("model_full_n", 32'(full_n), 32'(mq.size() != DEPTH));
      check("model_error", 32'(err), 32'(m_err));
    end
  end

  task automatic cyc(input bit w, input logic [W-1:0] d, input bit r);
    we  = w;
    din = d;
    re  = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int pw;
    int pr;
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    din = '0;
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset then idle
    cyc(1'b0, '0, 1'b0);
    check("rst_dataout", 32'(dout), 32'h00);
    check("rst_empty_n", 32'(empty_n), 32'h0);
    check("rst_half_n", 32'(half_n), 32'h1);
    check("rst_full_n", 32'(full_n), 32'h1);
    check("rst_error", 32'(err), 32'h0);

    // Four writes then four reads
    for (int i = 1; i <= 4; i++) cyc(1'b1, W'(i), 1'b0);
    check("w4_half_n", 32'(half_n), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("r4_data", 32'(dout), 32'(i));
    end
    check("r4_empty_n", 32'(empty_n), 32'h0);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(8'h10 + i), 1'b0);
    check("fill_full_n", 32'(full_n), 32'h0);
    cyc(1'b1, 8'hFF, 1'b0);
    check("ovf_error", 32'(err), 32'h1);
    check("ovf_full_n", 32'(full_n), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("drain_data", 32'(dout), 32'(8'h10 + i));
    end
    check("drain_empty_n", 32'(empty_n), 32'h0);

    // Underflow leaves DataOut untouched
    do_reset();
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, '0, 1'b1);
    check("pre_udf_data", 32'(dout), 32'h5A);
    check("pre_udf_error", 32'(err), 32'h0);
    cyc(1'b0, '0, 1'b1);
    check("udf_error", 32'(err), 32'h1);
    check("udf_data", 32'(dout), 32'h5A);
    check("udf_empty_n", 32'(empty_n), 32'h0);

    // Simultaneous write and read at count 4
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, W'(8'h20 + i), 1'b0);
    cyc(1'b1, 8'hAA, 1'b1);
    check("rw_data", 32'(dout), 32'h21);
    check("rw_half_n", 32'(half_n), 32'h0);
    check("rw_empty_n", 32'(empty_n), 32'h1);
    check("rw_full_n", 32'(full_n), 32'h1);
    cyc(1'b0, '0, 1'b1);
    check("rw_d1", 32'(dout), 32'h22);
    cyc(1'b0, '0, 1'b1);
    check("rw_d2", 32'(dout), 32'h23);
    cyc(1'b0, '0, 1'b1);
    check("rw_d3", 32'(dout), 32'h24);
    cyc(1'b0, '0, 1'b1);
    check("rw_last", 32'(dout), 32'hAA);
    check("rw_empty_end", 32'(empty_n), 32'h0);

    // Interleaved 20 values across two pointer wraps
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, W'(i), 1'b0);
      cyc(1'b0, '0, 1'b1);
      check("wrap_data", 32'(dout), 32'(i));
    end
    check("wrap_error", 32'(err), 32'h0);

    // Random traffic with phases biased toward full or empty, and occasional resets
    do_reset();
    pw = 80;
    pr = 30;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 150) == 0) begin
        pw = (pw > 50) ? 25 : 80;
        pr = (pw > 50) ? 30 : 75;
      end
      rst = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 99) < pw, W'($urandom), $urandom_range(0, 99) < pr);
    end
    rst = 1'b0;

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 8, number of entries (power of two, at least 4).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, bits per entry.
REQ-003 The module SHALL have port ReadClk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 The module SHALL have port WriteClk, input, 1 bit: kept for port compatibility, must be tied to the ReadClk net, and is unused internally.
REQ-005 The module SHALL have port Reset_, input, 1 bit: synchronous, active-high reset (the name is retained; the polarity is high).
REQ-006 The module SHALL have port WriteEn, input, 1 bit: write request, sampled on the rising edge.
REQ-007 The module SHALL have port DataIn, input, DATA_WIDTH bits: write data.
REQ-008 The module SHALL have port ReadEn, input, 1 bit: read request, sampled on the rising edge.
REQ-009 The module SHALL have port DataOut, output, DATA_WIDTH bits: registered read data.
REQ-010 The module SHALL have port Empty_, output, 1 bit: active-low, 0 when the FIFO holds 0 entries.
REQ-011 The module SHALL have port HalfFull_, output, 1 bit: active-low, 0 when the FIFO holds at least FIFO_DEPTH/2 entries.
REQ-012 The module SHALL have port Full_, output, 1 bit: active-low, 0 when the FIFO holds FIFO_DEPTH entries.
REQ-013 The module SHALL have port Error, output, 1 bit: sticky illegal-access indicator.

Function
REQ-014 Occupancy SHALL be tracked by a count from 0 to FIFO_DEPTH, plus write and read pointers of log2(FIFO_DEPTH) bits that wrap from FIFO_DEPTH-1 to 0.
REQ-015 A write SHALL be accepted on a rising edge when WriteEn=1 and either count<FIFO_DEPTH or a read is accepted on the same edge; DataIn is stored at the write pointer, and the write pointer increments.
REQ-016 A read SHALL be accepted on a rising edge when ReadEn=1 and count>0; the entry at the read pointer is loaded into DataOut on that edge, and the read pointer increments.
REQ-017 Read latency SHALL be one edge: DataOut is valid immediately after the accepting edge and holds its value until the next accepted read.
REQ-018 The FIFO SHALL have no write-to-read bypass: a read on an empty FIFO is rejected even when a write occurs on the same edge.
REQ-019 Count SHALL be updated by +1 for a write only, -1 for a read only, and unchanged when both or neither are accepted.
REQ-020 All flags SHALL be registered and SHALL reflect the count produced by the same edge that updates the count.
REQ-021 Error SHALL be set to 1 on the edge of a rejected write (WriteEn=1, full, no accepted read) or a rejected read (ReadEn=1, empty), and SHALL stay 1 until reset.
REQ-022 A rejected access SHALL change no pointer, count, memory entry or DataOut.
REQ-023 Data SHALL be returned in strict write order across pointer wrap-around.

Reset
REQ-024 When Reset_=1 on a rising edge, the module SHALL clear both pointers and the count, and drive DataOut=0, Empty_=0, HalfFull_=1, Full_=1 and Error=0.
REQ-025 Reset SHALL take priority over WriteEn and ReadEn, and a reset asserted mid-operation SHALL discard all stored contents.
REQ-026 Memory contents SHALL NOT be reset.

Structure
REQ-027 The constants FIFO_DEPTH and DATA_WIDTH defaults, and the pointer width derived as log2(FIFO_DEPTH), SHALL be placed in a shared package, fifo_pkg.
REQ-028 Storage SHALL be a simple dual-port RAM sub-module, sdpram, instanced as sdpram_i1, which wraps a core instanced as sdpram_i1 that holds the array mem_array[0:FIFO_DEPTH-1].
REQ-029 The array SHALL be reachable by hierarchical path as <fifo>.sdpram_i1.sdpram_i1.mem_array so that a bench can preload it.

Verification
REQ-030 Reset, then idle: the bench SHALL check Empty_=0, HalfFull_=1, Full_=1, Error=0 and DataOut=00.
REQ-031 Write 01,02,03,04 and then read 4 times: the bench SHALL check DataOut = 01,02,03,04 in order, HalfFull_=0 after the 4th write, and Empty_=0 after the last read.
REQ-032 Write 8 entries (10..17): the bench SHALL check Full_=0; a 9th write of FF SHALL set Error=1, and the following 8 reads SHALL return 10..17 with no FF.
REQ-033 Read on an empty FIFO: the bench SHALL check Error=1, DataOut unchanged, and Empty_ still 0.
REQ-034 With 4 entries stored, a simultaneous write of AA and read: the bench SHALL check that the oldest entry is returned, the count stays 4, and AA is read back last.
REQ-035 Write and read 20 values (00..13) interleaved: the bench SHALL check in-order data across two pointer wraps and Error=0.
